stack_seq: RTL and testbench

- Per-instruction stack sequencer for the stack processor.
- Accepts one decoded stack-effect class at a time and checks it against the current stack count (legal depth, no underflow/overflow).
- Sequences the register-file read/write addresses, ALU strobe and the 2-bit op that drives the stack-count register, whose value is fed back on sc.
- Sits between instruction decode and the stack-count register / register file.

---
 rtl/stack_seq_pkg.sv | 44 ++++
 rtl/stack_seq_chk.sv | 31 +++
 rtl/stack_seq.sv | 131 +++++++++++++
 tb/tb_stack_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_seq_pkg.sv
// Purpose: shared types and codes for the stack sequencer and its legality checker.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package stack_seq_pkg;

  // Stack-count register op codes (existing encoding; SC_HOLD takes the spare code).
  localparam logic [1:0] DES_2   = 2'b00;
  localparam logic [1:0] DES_1   = 2'b01;
  localparam logic [1:0] ADV_1   = 2'b10;
  localparam logic [1:0] SC_HOLD = 2'b11;

  // Fault codes reported on fault_code.
  localparam logic [1:0] FLT_NONE  = 2'b00;
  localparam logic [1:0] FLT_UNDER = 2'b01;
  localparam logic [1:0] FLT_OVER  = 2'b10;
  localparam logic [1:0] FLT_ILL   = 2'b11;

  typedef enum logic [2:0] {
    CLS_NOP    = 3'd0,
    CLS_PUSH   = 3'd1,
    CLS_POP    = 3'd2,
    CLS_POP2   = 3'd3,
    CLS_UNARY  = 3'd4,
    CLS_BINARY = 3'd5,
    CLS_DUP    = 3'd6
  } stk_cls_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WB    = 2'd2,
    FAULT = 2'd3
  } seq_state_t;

  // Minimum stack count a class needs before it may execute.
  function automatic logic [1:0] min_depth(input logic [2:0] c);
    case (c)
      CLS_POP, CLS_UNARY, CLS_DUP: min_depth = 2'd1;
      CLS_POP2, CLS_BINARY:        min_depth = 2'd2;
      default:                     min_depth = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stack_seq_chk.sv
// Purpose: combinational legality check of a stack class against a stack count.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; also used by decode for early hazard checks.
module stack_chk
  import stack_seq_pkg::*;
#(
  parameter int SC_W      = 4,
  parameter int MAX_DEPTH = 15
) (
  input  logic [2:0]      cls,
  input  logic [SC_W-1:0] sc,
  output logic            legal,
  output logic [1:0]      fault_code
);

  logic grows;

  // Classify: illegal encoding beats underflow, underflow beats overflow.
  always_comb begin
    grows      = (cls == CLS_PUSH) || (cls == CLS_DUP);
    fault_code = FLT_NONE;
    if (cls == 3'd7)
      fault_code = FLT_ILL;
    else if (sc < SC_W'(min_depth(cls)))
      fault_code = FLT_UNDER;
    else if (grows && (sc == SC_W'(MAX_DEPTH)))
      fault_code = FLT_OVER;
    legal = (fault_code == FLT_NONE);
  end

endmodule

// File: rtl/stack_seq.sv
// Purpose: per-instruction stack sequencer (legality, RF addresses, ALU strobe, sc_op).
// Latency: accept -> done 2 cycles; one class per 3 cycles.
// Backpressure: ready only in IDLE; FAULT holds ready low until reset
//               (or fault_clr when built with STACK_SEQ_FAULT_CLR_EN).
module stack_seq
  import stack_seq_pkg::*;
#(
  parameter int SC_W      = 4,
  parameter int MAX_DEPTH = 15
) (
  input  logic            clk,
  input  logic            reset,
`ifdef STACK_SEQ_FAULT_CLR_EN
  input  logic            fault_clr,
`endif
  input  logic            cls_valid,
  input  logic [2:0]      cls,
  output logic            ready,
  input  logic [SC_W-1:0] sc,
  output logic [1:0]      sc_op,
  output logic [SC_W-1:0] rd_addr_a,
  output logic [SC_W-1:0] rd_addr_b,
  output logic            rd_en,
  output logic            alu_go,
  output logic [SC_W-1:0] wr_addr,
  output logic            wr_en,
  output logic            done,
  output logic            fault,
  output logic [1:0]      fault_code
);

  seq_state_t      state;
  logic [2:0]      cls_q;
  logic [SC_W-1:0] sc_q;
  logic [1:0]      flt_q;
  logic            chk_legal;
  logic [1:0]      chk_code;
  logic [SC_W-1:0] sc_m1;
  logic [SC_W-1:0] sc_m2;

  // The checker looks at the live inputs in the accept cycle, which are
  // exactly the values being latched into cls_q/sc_q on that edge.
  stack_chk #(.SC_W(SC_W), .MAX_DEPTH(MAX_DEPTH)) u_chk (
    .cls        (cls),
    .sc         (sc),
    .legal      (chk_legal),
    .fault_code (chk_code)
  );

  // State, latched class/count and sticky fault code.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cls_q <= 3'd0;
      sc_q  <= '0;
      flt_q <= FLT_NONE;
    end else begin
      case (state)
        IDLE: if (cls_valid) begin
          cls_q <= cls;
          sc_q  <= sc;
          if (chk_legal) begin
            state <= EXEC;
          end else begin
            state <= FAULT;
            flt_q <= chk_code;
          end
        end
        EXEC: state <= WB;
        WB:   state <= IDLE;
        FAULT: begin
`ifdef STACK_SEQ_FAULT_CLR_EN
          if (fault_clr) begin
            state <= IDLE;
            flt_q <= FLT_NONE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from state and the latched class; sc is never consulted here.
  always_comb begin
    sc_m1      = sc_q - SC_W'(1);
    sc_m2      = sc_q - SC_W'(2);
    ready      = (state == IDLE);
    fault      = (state == FAULT);
    fault_code = flt_q;
    sc_op      = SC_HOLD;
    rd_addr_a  = '0;
    rd_addr_b  = '0;
    rd_en      = 1'b0;
    alu_go     = 1'b0;
    wr_addr    = '0;
    wr_en      = 1'b0;
    done       = 1'b0;
    if (state == EXEC) begin
      case (cls_q)
        CLS_UNARY: begin
          rd_en = 1'b1; rd_addr_a = sc_m1; alu_go = 1'b1;
        end
        CLS_BINARY: begin
          rd_en = 1'b1; rd_addr_a = sc_m1; rd_addr_b = sc_m2; alu_go = 1'b1;
        end
        CLS_DUP: begin
          rd_en = 1'b1; rd_addr_a = sc_m1;
        end
        default: ;
      endcase
    end else if (state == WB) begin
      done = 1'b1;
      case (cls_q)
        CLS_PUSH, CLS_DUP: begin
          wr_en = 1'b1; wr_addr = sc_q; sc_op = ADV_1;
        end
        CLS_POP:  sc_op = DES_1;
        CLS_POP2: sc_op = DES_2;
        CLS_UNARY: begin
          wr_en = 1'b1; wr_addr = sc_m1;
        end
        CLS_BINARY: begin
          wr_en = 1'b1; wr_addr = sc_m2; sc_op = DES_1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Purpose: scoreboard bench for stack_seq using directed classes.
// Latency: expectations queued at issue, popped by a negedge monitor.
// Backpressure: stimulus waits (bounded) on ready before each issue.
module tb_stack_seq;
  import stack_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cls_valid = 1'b0;
  logic [2:0] cls = 3'd0;
  logic [3:0] sc = 4'd0;
  logic       ready, rd_en, alu_go, wr_en, done, fault;
  logic [1:0] sc_op, fault_code;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr;
`ifdef STACK_SEQ_FAULT_CLR_EN
  logic       fault_clr = 1'b0;
`endif

  stack_seq #(.SC_W(4), .MAX_DEPTH(15)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef STACK_SEQ_FAULT_CLR_EN
    .fault_clr  (fault_clr),
`endif
    .cls_valid  (cls_valid),
    .cls        (cls),
    .ready      (ready),
    .sc         (sc),
    .sc_op      (sc_op),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_en      (rd_en),
    .alu_go     (alu_go),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .done       (done),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic en; logic [3:0] ra; logic [3:0] rb; logic alu;} ex_t;
  typedef struct packed {logic we; logic [3:0] wa; logic [1:0] op;} wb_t;

  ex_t        ex_q[$];
  wb_t        wb_q[$];
  logic [1:0] flt_q[$];
  ex_t        ex_exp;
  wb_t        wb_exp;
  logic [1:0] flt_exp;

  int   n_chk = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;
  logic fault_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event with no expectation pending", name);
  endtask

  // Monitor: pops an expectation whenever the DUT presents an EXEC, WB or fault event.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_en || alu_go) begin
        if (ex_q.size() == 0) fail_now("exec_unexpected");
        else begin
          ex_exp = ex_q.pop_front();
          check("exec_strobes", {rd_en, rd_addr_a, rd_addr_b, alu_go}, ex_exp);
        end
      end
      if (done) begin
        if (wb_q.size() == 0) fail_now("done_unexpected");
        else begin
          wb_exp = wb_q.pop_front();
          check("wb_outputs", {wr_en, wr_addr, sc_op}, wb_exp);
        end
      end else begin
        check("no_wb_strobe", {wr_en, sc_op}, {1'b0, SC_HOLD});
      end
      if (fault && !fault_prev) begin
        if (flt_q.size() == 0) fail_now("fault_unexpected");
        else begin
          flt_exp = flt_q.pop_front();
          check("fault_code", fault_code, flt_exp);
        end
      end
      fault_prev = fault;
    end
  end

  // Issue one class once ready is seen; returns just after the accept edge.
  task automatic send(input logic [2:0] c, input logic [3:0] s);
    int t = 0;
    @(negedge clk);
    while (!ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!ready) fail_now("ready_timeout");
    cls_valid = 1'b1;
    cls = c;
    sc = s;
    @(posedge clk);
    #1 cls_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_sc_op", sc_op, SC_HOLD);
    check("rst_strobes", {rd_en, alu_go, wr_en, done, fault}, 5'b0);
    check("rst_fault_code", fault_code, 2'b00);
    check("rst_addrs", {rd_addr_a, rd_addr_b, wr_addr}, 12'h000);
    reset = 1'b0;
    mon_en = 1'b1;

    // PUSH at empty stack, with ready timing
    wb_q.push_back(wb_t'{1'b1, 4'd0, ADV_1});
    send(CLS_PUSH, 4'd0);
    @(negedge clk); check("ready_c1", ready, 1'b0);
    @(negedge clk); check("ready_c2", ready, 1'b0);
                    check("done_c2", done, 1'b1);
    @(negedge clk); check("ready_c3", ready, 1'b1);

    // BINARY at sc=5
    ex_q.push_back(ex_t'{1'b1, 4'd4, 4'd3, 1'b1});
    wb_q.push_back(wb_t'{1'b1, 4'd3, DES_1});
    send(CLS_BINARY, 4'd5);

    // NOP, POP, DUP
    wb_q.push_back(wb_t'{1'b0, 4'd0, SC_HOLD});
    send(CLS_NOP, 4'd0);
    wb_q.push_back(wb_t'{1'b0, 4'd0, DES_1});
    send(CLS_POP, 4'd3);
    ex_q.push_back(ex_t'{1'b1, 4'd3, 4'd0, 1'b0});
    wb_q.push_back(wb_t'{1'b1, 4'd4, ADV_1});
    send(CLS_DUP, 4'd4);

    // UNARY at sc=3, sc disturbed to 9 after accept
    ex_q.push_back(ex_t'{1'b1, 4'd2, 4'd0, 1'b1});
    wb_q.push_back(wb_t'{1'b1, 4'd2, SC_HOLD});
    send(CLS_UNARY, 4'd3);
    sc = 4'd9;
    idle(3);

    // Boundaries: POP2 at exactly 2, PUSH at 14
    wb_q.push_back(wb_t'{1'b0, 4'd0, DES_2});
    send(CLS_POP2, 4'd2);
    wb_q.push_back(wb_t'{1'b1, 4'd14, ADV_1});
    send(CLS_PUSH, 4'd14);

    // Reset in EXEC aborts the class
    send(CLS_PUSH, 4'd3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    check("abort_ready", ready, 1'b1);

    // Underflow fault, ignored request, reset recovery
    flt_q.push_back(2'b01);
    send(CLS_POP2, 4'd1);
    @(negedge clk);
    check("flt_ready", ready, 1'b0);
    check("flt_fault", fault, 1'b1);
    cls_valid = 1'b1; cls = CLS_PUSH; sc = 4'd0;
    idle(4);
    cls_valid = 1'b0;
    check("flt_code_held", fault_code, 2'b01);
    check("flt_ready_held", ready, 1'b0);
    pulse_reset();
    check("rec_fault", fault, 1'b0);
    check("rec_ready", ready, 1'b1);
    check("rec_code", fault_code, 2'b00);

    // Overflow, then illegal-over-underflow
    flt_q.push_back(2'b10);
    send(CLS_DUP, 4'd15);
    idle(2);
    pulse_reset();
    flt_q.push_back(2'b11);
    send(3'd7, 4'd0);
    idle(2);
    pulse_reset();

`ifdef STACK_SEQ_FAULT_CLR_EN
    // Fault clear returns to IDLE without reset
    flt_q.push_back(2'b01);
    send(CLS_POP, 4'd0);
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("clr_ready", ready, 1'b1);
    check("clr_fault", fault, 1'b0);
    check("clr_code", fault_code, 2'b00);
    wb_q.push_back(wb_t'{1'b1, 4'd1, ADV_1});
    send(CLS_PUSH, 4'd1);
`endif

    idle(5);
    mon_en = 1'b0;
    check("ex_q_drained", ex_q.size(), 0);
    check("wb_q_drained", wb_q.size(), 0);
    check("flt_q_drained", flt_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
